// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM channel scheduler.
package pwm_sched_pkg;

    // Scheduler FSM states, visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_MEASURE   = 3'd4,
        ST_PRESENT   = 3'd5
    } state_t;

    localparam int DEF_COUNT_W = 8;
    localparam int DEF_TIMEOUT = 65535;
    localparam int TMO_W       = 16;

endpackage

// File: rtl/pwm_width_counter.sv
// Saturating pulse-width counter shared by all channels.
// clear has priority; clear together with inc loads 1 so the first high
// cycle of a pulse is already counted.
module pwm_width_counter
    import pwm_sched_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               clear,
    input  logic               inc,
    output logic [COUNT_W-1:0] value
);

    logic [COUNT_W-1:0] r_value;

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= inc ? COUNT_W'(1) : '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + COUNT_W'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Round-robin PWM high-pulse width scheduler.
// One width counter is time-shared over N_CH synchronized PWM inputs; each
// result {channel, width} is offered on a valid/ready port.
// Optional feature macro: PWM_SCHED_TIMEOUT_EN (per-channel wait timeout).
//
// Handshake: ResValid rises with stable ChanOut/CountOut/TimeoutOut and those
// hold until a cycle with ResValid && ResReady, which is the transfer cycle.
module pwm_channel_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_CH-1:0]    PWMIn,
    input  logic [N_CH-1:0]    ChEnable,
    output logic [COUNT_W-1:0] CountOut,
    output logic [CH_W-1:0]    ChanOut,
    output logic               TimeoutOut,
    output logic               ResValid,
    input  logic               ResReady,
    output logic               Busy,
    output logic [2:0]         o_dbg_state
);

    logic [N_CH-1:0]    r_sync1;
    logic [N_CH-1:0]    r_sync2;
    state_t             r_state;
    logic [CH_W-1:0]    r_chan;
    logic [CH_W-1:0]    r_last;
    logic [COUNT_W-1:0] r_count_out;
    logic [CH_W-1:0]    r_chan_out;
    logic               r_timeout_out;
    logic               r_res_valid;

    logic               w_pwm_s;
    logic               w_in_wait;
    logic               w_tmo_hit;
    logic               w_cnt_clear;
    logic               w_cnt_inc;
    logic [COUNT_W-1:0] w_cnt_value;
    logic [CH_W-1:0]    w_next_ch;
    logic               w_found;

    // Two-flop synchronizer on every PWM pin.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PWMIn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pwm_s   = r_sync2[r_chan];
    assign w_in_wait = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH) ||
                       (r_state == ST_MEASURE);

    // Next enabled channel strictly after the last served one, wrapping.
    always_comb begin
        int v_idx;
        w_next_ch = r_last;
        w_found   = 1'b0;
        v_idx     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            v_idx = (int'(r_last) + i) % N_CH;
            if (!w_found && ChEnable[CH_W'(v_idx)]) begin
                w_next_ch = CH_W'(v_idx);
                w_found   = 1'b1;
            end
        end
    end

`ifdef PWM_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;

    // Wait budget: loaded on selection, counts down while waiting/measuring.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tmo <= '0;
        end else if (r_state == ST_SELECT) begin
            r_tmo <= TMO_W'(TIMEOUT);
        end else if (w_in_wait && (r_tmo != '0)) begin
            r_tmo <= r_tmo - TMO_W'(1);
        end
    end

    // The cycle that takes the budget to zero ends the wait.
    assign w_tmo_hit = w_in_wait && (r_tmo <= TMO_W'(1));
`else
    logic [TMO_W-1:0] w_unused_tmo;
    assign w_unused_tmo = TMO_W'(TIMEOUT);
    assign w_tmo_hit    = 1'b0;
`endif

    // First high cycle restarts the counter at 1; later high cycles add one.
    assign w_cnt_clear = (r_state == ST_WAIT_HIGH) && w_pwm_s;
    assign w_cnt_inc   = w_pwm_s && ((r_state == ST_WAIT_HIGH) || (r_state == ST_MEASURE));

    pwm_width_counter #(
        .COUNT_W (COUNT_W)
    ) u_width_counter (
        .i_clk (CLK),
        .i_rst (RST),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .value (w_cnt_value)
    );

    // Scheduler FSM with registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_chan        <= '0;
            r_last        <= CH_W'(N_CH - 1);
            r_count_out   <= '0;
            r_chan_out    <= '0;
            r_timeout_out <= 1'b0;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|ChEnable) begin
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (w_found) begin
                        r_chan  <= w_next_ch;
                        r_last  <= w_next_ch;
                        r_state <= ST_WAIT_LOW;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_LOW, ST_WAIT_HIGH, ST_MEASURE: begin
                    if (w_tmo_hit) begin
                        r_count_out   <= '0;
                        r_chan_out    <= r_chan;
                        r_timeout_out <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_PRESENT;
                    end else if ((r_state == ST_WAIT_LOW) && !w_pwm_s) begin
                        r_state <= ST_WAIT_HIGH;
                    end else if ((r_state == ST_WAIT_HIGH) && w_pwm_s) begin
                        r_state <= ST_MEASURE;
                    end else if ((r_state == ST_MEASURE) && !w_pwm_s) begin
                        r_count_out   <= w_cnt_value;
                        r_chan_out    <= r_chan;
                        r_timeout_out <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ResReady) begin
                        r_res_valid <= 1'b0;
                        r_state     <= (|ChEnable) ? ST_SELECT : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CountOut    = r_count_out;
    assign ChanOut     = r_chan_out;
    assign TimeoutOut  = r_timeout_out;
    assign ResValid    = r_res_valid;
    assign Busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: doc/pwm_channel_scheduler.md
# pwm_channel_scheduler

Time-multiplexes one PWM pulse-width measurement datapath across `N_CH` PWM inputs for the ultrasound range finder. Selects channels round-robin, waits for a complete high pulse on the selected input, counts its width in `CLK` cycles, and presents `{channel, width}` on a valid/ready result port. Sits between the echo/PWM pins and the range-processing logic.

## Interface
- `N_CH`, 4: number of PWM input channels, 2..16
- `CH_W`, 2: channel index width, clog2(`N_CH`)
- `COUNT_W`, 8: pulse-width count width
- `TIMEOUT`, 65535: max cycles spent waiting on one channel, 16-bit

- `CLK` in 1: sampling clock (PWM freq × 2^`COUNT_W`)
- `RST` in 1: synchronous, active-high reset
- `PWMIn` in `N_CH`: asynchronous PWM inputs, one bit per channel
- `ChEnable` in `N_CH`: per-channel enable mask, sampled when choosing the next channel
- `CountOut` out `COUNT_W`: measured high-pulse width
- `ChanOut` out `CH_W`: channel index of the result
- `TimeoutOut` out 1: result is a timeout, not a measurement
- `ResValid` out 1: result valid
- `ResReady` in 1: consumer accepts the result
- `Busy` out 1: FSM not in IDLE

## Operation
- Each `PWMIn` bit passes through a 2-flop synchronizer. The FSM sees only the synchronized value of the selected channel, `pwm_s`.
- States:
  - IDLE: no enabled channel. Go to SELECT when `ChEnable != 0`.
  - SELECT: pick the next enabled channel after the last served one, round-robin, wrapping `N_CH-1`→0. Load the timeout counter. Go to WAIT_LOW.
  - WAIT_LOW: wait for `pwm_s==0`. This guarantees a full pulse is measured and never a partial one. Go to WAIT_HIGH.
  - WAIT_HIGH: wait for `pwm_s==1`. On the rising edge, set count to 1 and go to MEASURE.
  - MEASURE: increment the count each cycle `pwm_s==1`. The count saturates at 2^`COUNT_W`−1 and does not wrap. On `pwm_s==0`, latch the result and go to PRESENT.
  - PRESENT: hold `ResValid=1` and the stable outputs until `ResReady`. On the accept cycle, go to SELECT, or to IDLE if `ChEnable==0`.
- Timeout:
  - The counter decrements in WAIT_LOW, WAIT_HIGH and MEASURE.
  - On reaching 0, go to PRESENT with `TimeoutOut=1` and `CountOut=0`.
- `ChEnable` is ignored mid-measurement. Clearing the enable of the active channel does not abort it.
- A single enabled channel is reselected back-to-back.

## Timing
- Reset values: `CountOut=0`, `ChanOut=0`, `TimeoutOut=0`, `ResValid=0`, `Busy=0`, state IDLE, last-served pointer `N_CH-1` so channel 0 is served first, synchronizers 0.
- Input latency: 2 cycles, pin to `pwm_s`.
- Width result: a high pulse of H `CLK` cycles yields `CountOut=H`, saturated.
- `ResValid` rises the cycle after the falling edge is seen in MEASURE.
- Handshake: transfer occurs on a cycle with `ResValid && ResReady`. Outputs hold while `ResValid && !ResReady`.
- Throughput: SELECT follows the accept by 1 cycle. The minimum cost is 1 cycle per channel switch plus the waiting.
- `RST` mid-operation returns the block to IDLE next cycle and drops a pending result.

## Configuration
- `PWM_SCHED_TIMEOUT_EN`
  - Defined: timeout counter and `TimeoutOut` behave as above.
  - Undefined: no timeout logic; `TimeoutOut` is tied 0, and a dead channel stalls the scheduler indefinitely.

## Structure
- Package `pwm_sched_pkg`:
  - FSM state enum: IDLE, SELECT, WAIT_LOW, WAIT_HIGH, MEASURE, PRESENT
  - default `COUNT_W` and `TIMEOUT` constants
- Sub-module `pwm_width_counter`:
  - Saturating `COUNT_W` counter with `clear`, `inc` and `value` ports.
  - Instantiated once. It is the shared datapath that the scheduler sequences.

## Test plan
- Reset, `ChEnable=4'b0001`, channel 0 high pulse of 37 cycles → `ResValid` with `ChanOut=0`, `CountOut=37`, `TimeoutOut=0`.
- Input high at selection time, 10 cycles high then low, then a 20-cycle pulse → the partial pulse is ignored and `CountOut=20`.
- `ChEnable=4'b1011`, each channel pulsing → result order 0,1,3,0,1,3, and channel 2 never appears.
- 300-cycle high pulse with `COUNT_W=8` → `CountOut=255`.
- `ResReady=0` for 50 cycles during PRESENT → outputs stable and no new selection; accept → SELECT next cycle.
- With `PWM_SCHED_TIMEOUT_EN`, `TIMEOUT=100`, channel 1 held low → result `ChanOut=1`, `TimeoutOut=1`, `CountOut=0`. Then assert `RST` during MEASURE on the next channel → all outputs return to reset values next cycle.
